// File: rtl/game_master_fsm.sv
// game_master_fsm: button-started game controller tracking score and lives.
// Define GAME_TIMEOUT_EN to add an inactivity timeout in PLAY (TIMEOUT_CYCLES).
module game_master_fsm #(
   parameter int NUM_BTN        = 4,
   parameter int SCORE_W        = 8,
   parameter int TARGET_SCORE   = 10,
   parameter int LIVES          = 3,
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_BTN-1:0] BTN,
   input  logic               SCORE_INC,
   input  logic               FAIL,
   output logic               TRIG,
   output logic [1:0]         STATE,
   output logic [SCORE_W-1:0] SCORE,
   output logic [2:0]         LIVES_LEFT
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      WIN  = 2'b10,
      LOSE = 2'b11
   } state_t;

   if (TARGET_SCORE < 1 || TARGET_SCORE >= (1 << SCORE_W)) begin : g_bad_target
      $error("TARGET_SCORE outside 1 .. 2**SCORE_W-1");
   end
   if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
      $error("LIVES outside 1 .. 7");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t             state, state_next;
   logic [SCORE_W-1:0] score, score_next;
   logic [2:0]         lives, lives_next;
   logic               trig, trig_next;
   logic [NUM_BTN-1:0] btn_q;
   logic [NUM_BTN-1:0] btn_hold, btn_hold_next;
   logic               btn_event;
   logic               timed_out;

   // btn_hold masks buttons that were already down at reset until they are released.
   assign btn_event = |(BTN & ~btn_q & ~btn_hold);

`ifdef GAME_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] idle_cnt, idle_cnt_next;

   assign timed_out = (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !btn_event && !SCORE_INC;

   always_comb begin
      idle_cnt_next = '0;
      if (state == PLAY && state_next == PLAY && !btn_event && !SCORE_INC)
         idle_cnt_next = idle_cnt + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) idle_cnt <= '0;
      else       idle_cnt <= idle_cnt_next;
   end
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      // NOTE: every register here uses <= so all of them see the pre-edge values.
      if (RESET) begin
         state    <= IDLE;
         score    <= '0;
         lives    <= 3'(LIVES);
         trig     <= 1'b0;
         btn_q    <= '0;
         btn_hold <= BTN;
      end else begin
         state    <= state_next;
         score    <= score_next;
         lives    <= lives_next;
         trig     <= trig_next;
         btn_q    <= BTN;
         btn_hold <= btn_hold_next;
      end
   end

   always_comb begin
      // NOTE: defaults first, so no path through this block can infer a latch.
      state_next    = state;
      score_next    = score;
      lives_next    = lives;
      trig_next     = 1'b0;
      btn_hold_next = btn_hold & BTN;
      case (state)
         IDLE: begin
            if (btn_event) begin
               state_next = PLAY;
               score_next = '0;
               lives_next = 3'(LIVES);
               trig_next  = 1'b1;
            end
         end
         PLAY: begin
            // Score is always below target in PLAY, so the increment cannot overshoot.
            if (SCORE_INC)
               score_next = score + 1'b1;
            if (FAIL && lives != 3'd0)
               lives_next = lives - 3'd1;
            if (score_next == SCORE_W'(TARGET_SCORE))
               state_next = WIN;
            else if (lives_next == 3'd0)
               state_next = LOSE;
            else if (timed_out) begin
               state_next = LOSE;
               lives_next = 3'd0;
            end
         end
         WIN, LOSE: begin
            if (btn_event)
               state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      STATE      = state;
      SCORE      = score;
      LIVES_LEFT = lives;
      TRIG       = trig;
   end

endmodule

// File: tb/tb_game_master_fsm.sv
// Bench for game_master_fsm: a rule-level model checked every cycle plus directed literals.
module tb_game_master_fsm;

   localparam int NUM_BTN = 4;
   localparam int SCORE_W = 8;
   localparam int TARGET  = 10;
   localparam int LIVES   = 3;
   localparam int TMO     = 16;

   localparam int S_IDLE = 0;
   localparam int S_PLAY = 1;
   localparam int S_WIN  = 2;
   localparam int S_LOSE = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_BTN-1:0] btn;
   logic               inc;
   logic               fl;
   logic               trig;
   logic [1:0]         state;
   logic [SCORE_W-1:0] score;
   logic [2:0]         lives;

   int checks = 0;
   int errors = 0;

   game_master_fsm #(
      .NUM_BTN(NUM_BTN), .SCORE_W(SCORE_W), .TARGET_SCORE(TARGET),
      .LIVES(LIVES), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(clk), .RESET(rst), .BTN(btn), .SCORE_INC(inc), .FAIL(fl),
      .TRIG(trig), .STATE(state), .SCORE(score), .LIVES_LEFT(lives)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Game model: rules applied to the inputs seen at each rising edge.
   int                 m_state, m_score, m_lives, m_quiet;
   bit                 m_trig;
   logic [NUM_BTN-1:0] m_prev, m_held;
   bit                 model_ok = 1'b0;
   bit                 pressed;

   always @(posedge clk) begin
      if (rst) begin
         m_state  = S_IDLE;
         m_score  = 0;
         m_lives  = LIVES;
         m_trig   = 1'b0;
         m_quiet  = 0;
         m_prev   = '0;
         m_held   = btn;
         model_ok = 1'b1;
      end else begin
         pressed = |(btn & ~m_prev & ~m_held);
         m_held  = m_held & btn;
         m_prev  = btn;
         m_trig  = 1'b0;
         if (m_state == S_IDLE) begin
            if (pressed) begin
               m_state = S_PLAY;
               m_score = 0;
               m_lives = LIVES;
               m_trig  = 1'b1;
               m_quiet = 0;
            end
         end else if (m_state == S_PLAY) begin
            if (inc) m_score = m_score + 1;
            if (fl && m_lives > 0) m_lives = m_lives - 1;
            m_quiet = (pressed || inc) ? 0 : m_quiet + 1;
            if (m_score == TARGET) m_state = S_WIN;
            else if (m_lives == 0) m_state = S_LOSE;
`ifdef GAME_TIMEOUT_EN
            else if (m_quiet >= TMO) begin
               m_state = S_LOSE;
               m_lives = 0;
            end
`endif
         end else if (pressed) begin
            m_state = S_IDLE;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("state", 32'(state), 32'(m_state));
         check("score", 32'(score), 32'(m_score));
         check("lives", 32'(lives), 32'(m_lives));
         check("trig",  32'(trig),  32'(m_trig));
      end
   end

   task automatic tick(input logic [NUM_BTN-1:0] b, input logic i, input logic f);
      rst = 1'b0; btn = b; inc = i; fl = f;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset with score/fail asserted to show that reset overrides them.
   task automatic reset_tick(input logic [NUM_BTN-1:0] b);
      rst = 1'b1; btn = b; inc = 1'b1; fl = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; btn = '0; inc = 1'b0; fl = 1'b0;
      reset_tick(4'b0000);
      reset_tick(4'b0000);
      check("rst_state", 32'(state), 0);
      check("rst_score", 32'(score), 0);
      check("rst_lives", 32'(lives), 3);
      check("rst_trig",  32'(trig),  0);

      // Start from IDLE; held button gives no repeat.
      tick(4'b0001, 1'b0, 1'b0);
      check("start_state", 32'(state), 1);
      check("start_trig",  32'(trig),  1);
      check("start_score", 32'(score), 0);
      check("start_lives", 32'(lives), 3);
      tick(4'b0001, 1'b0, 1'b0);
      check("trig_one_cycle", 32'(trig), 0);
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b0001, 1'b0, 1'b0);
      check("held_btn_state", 32'(state), 1);

      // Score to target.
      for (int i = 1; i <= 10; i++) begin
         tick(4'b0000, 1'b1, 1'b0);
         check("score_count", 32'(score), 32'(i));
         check("score_state", 32'(state), (i < 10) ? 1 : 2);
      end
      tick(4'b0000, 1'b1, 1'b0);
      check("win_score_frozen", 32'(score), 10);
      tick(4'b0000, 1'b0, 1'b1);
      check("win_lives_frozen", 32'(lives), 3);
      tick(4'b0010, 1'b0, 1'b0);
      check("win_to_idle", 32'(state), 0);
      check("idle_keeps_score", 32'(score), 10);
      tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0000, 1'b1, 1'b1);
      check("idle_ignores_inc",  32'(score), 10);
      check("idle_ignores_fail", 32'(lives), 3);

      // Lose all lives.
      tick(4'b0100, 1'b0, 1'b0);
      check("restart_score", 32'(score), 0);
      check("restart_trig",  32'(trig),  1);
      tick(4'b0000, 1'b1, 1'b0);
      tick(4'b0000, 1'b1, 1'b0);
      tick(4'b0000, 1'b0, 1'b1);
      check("lives_2", 32'(lives), 2);
      tick(4'b0000, 1'b0, 1'b1);
      check("lives_1", 32'(lives), 1);
      tick(4'b0000, 1'b0, 1'b1);
      check("lives_0", 32'(lives), 0);
      check("lose_state", 32'(state), 3);
      tick(4'b0000, 1'b1, 1'b0);
      check("lose_score_frozen", 32'(score), 2);
      tick(4'b1000, 1'b0, 1'b0);
      check("lose_to_idle", 32'(state), 0);
      check("lose_idle_score", 32'(score), 2);
      check("lose_idle_lives", 32'(lives), 0);
      tick(4'b0000, 1'b0, 1'b0);

      // Simultaneous score and fail at score 9, lives 1.
      tick(4'b0001, 1'b0, 1'b0);
      check("start2_lives", 32'(lives), 3);
      tick(4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) tick(4'b0000, 1'b1, 1'b0);
      tick(4'b0010, 1'b0, 1'b0);
      check("play_btn_no_change", 32'(state), 1);
      tick(4'b0000, 1'b0, 1'b1);
      tick(4'b0000, 1'b0, 1'b1);
      check("pre_both_score", 32'(score), 9);
      check("pre_both_lives", 32'(lives), 1);
      tick(4'b0000, 1'b1, 1'b1);
      check("both_state", 32'(state), 2);
      check("both_score", 32'(score), 10);
      check("both_lives", 32'(lives), 0);

      // Reset in the middle of PLAY.
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b0000, 1'b1, 1'b0);
      tick(4'b0000, 1'b1, 1'b0);
      tick(4'b0000, 1'b1, 1'b1);
      check("mid_play_score", 32'(score), 3);
      reset_tick(4'b0000);
      check("mid_rst_state", 32'(state), 0);
      check("mid_rst_score", 32'(score), 0);
      check("mid_rst_lives", 32'(lives), 3);

      // Button held through reset must be released before it counts.
      reset_tick(4'b0001);
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b0001, 1'b0, 1'b0);
      check("held_at_reset", 32'(state), 0);
      tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0001, 1'b0, 1'b0);
      check("repress_state", 32'(state), 1);
      check("repress_trig",  32'(trig),  1);

      // Inactivity in PLAY.
      reset_tick(4'b0000);
      tick(4'b0001, 1'b0, 1'b0);
`ifdef GAME_TIMEOUT_EN
      for (int k = 1; k <= 15; k++) tick(4'b0000, 1'b0, 1'b0);
      check("tmo_before", 32'(state), 1);
      tick(4'b0000, 1'b0, 1'b0);
      check("tmo_state", 32'(state), 3);
      check("tmo_lives", 32'(lives), 0);
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0001, 1'b0, 1'b0);
      for (int k = 1; k <= 9; k++) tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0010, 1'b0, 1'b0);
      for (int k = 1; k <= 15; k++) tick(4'b0000, 1'b0, 1'b0);
      check("tmo_postponed", 32'(state), 1);
      tick(4'b0000, 1'b0, 1'b0);
      check("tmo_late_state", 32'(state), 3);
`else
      for (int k = 1; k <= 40; k++) tick(4'b0000, 1'b0, 1'b0);
      check("no_tmo_state", 32'(state), 1);
      check("no_tmo_lives", 32'(lives), 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
